if_prefetch_queue: RTL
======================

// Module: if_prefetch_queue
// PURPOSE
//  Instruction-fetch front end that sits directly upstream of the core's decode/execute datapath.
//  Generates sequential fetch addresses and issues them to instruction memory over a req/ack handshake
//  that tolerates variable memory latency.
//  Buffers returned words with their PCs in a small FIFO and hands them to the core over valid/ready.
//  Flushes and refetches when the core redirects on a branch, jal or jalr.
// PARAMETERS
//  DEPTH     4      FIFO entries; power of two, >=2
//  XLEN      32     instruction and address width
//  RESET_PC  32'h0  first fetch address after reset
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              synchronous, active-high reset
//  redirect     in   1              core requests a flush and restart at redirect_pc
//  redirect_pc  in   XLEN           new fetch address; bits [1:0] forced to 0
//  imem_req     out  1              fetch request valid
//  imem_addr    out  XLEN           fetch address; word aligned
//  imem_ack     in   1              memory accepts the request and returns imem_rdata in the same cycle
//  imem_rdata   in   XLEN           fetched instruction word
//  inst_valid   out  1              FIFO head holds a valid instruction
//  inst_ready   in   1              core consumes the head this cycle
//  inst_out     out  XLEN           instruction at the FIFO head
//  inst_pc      out  XLEN           PC of inst_out
//  count        out  $clog2(DEPTH)+1  number of occupied FIFO entries
// BEHAVIOUR
//  Reset:
//   - fetch_pc=RESET_PC; FIFO pointers and count=0; FSM=IDLE; imem_req=0; inst_valid=0.
//   - A request outstanding at reset is abandoned; memory must drop it.
//  FSM states: IDLE, REQ, DRAIN.
//   - IDLE -> REQ when count + (1 if a push occurs this cycle) < DEPTH and no redirect. IDLE is a credit check only.
//   - REQ: imem_req=1, imem_addr=fetch_pc; both held stable until imem_ack. At most one request outstanding.
//   - REQ with imem_ack and no redirect: push {imem_rdata, fetch_pc}; fetch_pc += 4 mod 2^XLEN (0xFFFFFFFC -> 0).
//     Then stay in REQ if credit remains, else go to IDLE.
//   - REQ with redirect and no imem_ack: go to DRAIN; fetch_pc=redirect_pc.
//   - REQ with redirect and imem_ack in the same cycle: discard the word; fetch_pc=redirect_pc; go to IDLE.
//   - DRAIN: keep imem_req=1 and the old imem_addr until imem_ack; discard the data; then go to IDLE.
//     A further redirect while in DRAIN only updates fetch_pc.
//  Redirect:
//   - Flushes the FIFO (count=0) at the clock edge; no push occurs that cycle.
//   - redirect takes priority over a simultaneous pop and a simultaneous push.
//   - inst_valid=0 in the cycle after redirect.
//  FIFO:
//   - inst_valid = (count != 0); inst_out/inst_pc are read combinationally from the head of a registered array.
//   - Pop when inst_valid && inst_ready; inst_ready is ignored when empty.
//   - Push and pop in the same cycle leave count unchanged.
//   - No bypass: a word pushed into an empty FIFO is visible the next cycle.
//   - Full is never overrun; the credit rule guarantees it. Pointers wrap modulo DEPTH.
//  Latency:
//   - Minimum of 1 cycle from imem_ack to inst_valid.
//   - After reset release: imem_req rises in the first cycle; with a zero-wait ack, inst_valid rises in the second.
//   - Sustained throughput is 1 instr/cycle with zero-wait memory and inst_ready held high.
// TESTING
//  T1: reset, imem_ack tied high, inst_ready=1
//      -> inst_pc sequence 0,4,8,12... one per cycle from cycle 2; inst_out matches memory contents.
//  T2: inst_ready=0, zero-wait memory
//      -> count saturates at DEPTH=4; imem_req stays 0 afterwards; release inst_ready
//      -> the 4 buffered words drain in order, then fetching resumes at PC 16.
//  T3: memory with 3 wait states -> imem_addr is stable for 4 cycles per request; inst_valid follows each ack by 1 cycle.
//  T4: redirect to 0x100 while a request to 0x8 is outstanding
//      -> FSM enters DRAIN; the 0x8 data is discarded; the next imem_addr is 0x100; the first inst_pc is 0x100.
//  T5: redirect asserted together with a pop and an ack with count=2
//      -> count=0 next cycle; inst_valid=0; no stale PC is ever delivered.
//  T6: RESET_PC=0xFFFFFFF8 -> inst_pc sequence FFFFFFF8, FFFFFFFC, 00000000;
//      assert reset mid-REQ -> imem_req=0 and count=0 on the next cycle.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
// rtl/if_prefetch_queue_if.sv - fetch front end bus: redirect, imem req/ack, instruction valid/ready
interface if_prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] inst_pc;
  logic [CW-1:0]   count;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, count
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, count
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - sequential instruction prefetcher with credit-limited FIFO and redirect flush
module if_prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  if_prefetch_queue_if.master bus
);
  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] word_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;

  assign target_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign pop       = (count_q != '0) && bus.inst_ready;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drain_addr_d  = drain_addr_q;
    push          = 1'b0;
    bus.imem_req  = 1'b0;
    bus.imem_addr = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (!bus.redirect && (count_q < FULL)) state_d = REQ;
      end
      REQ: begin
        bus.imem_req = 1'b1;
        if (bus.redirect) begin
          drain_addr_d = fetch_pc_q;
          state_d      = bus.imem_ack ? IDLE : DRAIN;
        end else if (bus.imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = ((count_q + CW'(1) - CW'(pop)) < FULL) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        // Memory still owns the abandoned request; keep presenting it until acked.
        bus.imem_req  = 1'b1;
        bus.imem_addr = drain_addr_q;
        if (bus.imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.redirect) begin
      fetch_pc_d = target_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr_q] <= bus.imem_rdata;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_out   = word_q[rd_ptr_q];
  assign bus.inst_pc    = pc_q[rd_ptr_q];
  assign bus.count      = count_q;
endmodule
